zap_cp15_sequencer: RTL and testbench

- Executes the CP15 coprocessor word issued by the predecode coprocessor stage.
- Owns the CP15 register file (ID, control, TTBR, DAC, FSR, FAR).
- Sequences core register-file transfers for MCR/MRC and launches cache/TLB maintenance.
- Returns completion through a four-phase dav/done handshake; the predecode stage holds the pipeline stalled until then.

---
 rtl/zap_cp15_sequencer_pkg.sv | 56 +++++
 rtl/zap_cp15_sequencer_if.sv | 29 ++
 rtl/zap_cp15_sequencer_regfile.sv | 61 ++++++
 rtl/zap_cp15_sequencer.sv | 134 +++++++++++++
 tb/tb_zap_cp15_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/zap_cp15_sequencer_pkg.sv
// Shared CP15 sequencer constants: states, register numbers, maintenance bits.
// Also carries the architectural-to-physical register translation used by decode.
package zap_cp15_sequencer_pkg;

    localparam int PHY_REGS = 46;
    localparam int RW       = $clog2(PHY_REGS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_WRREG = 3'd3;
    localparam logic [2:0] S_MAINT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0] CR_ID    = 4'd0;
    localparam logic [3:0] CR_CTRL  = 4'd1;
    localparam logic [3:0] CR_TTBR  = 4'd2;
    localparam logic [3:0] CR_DAC   = 4'd3;
    localparam logic [3:0] CR_FSR   = 4'd5;
    localparam logic [3:0] CR_FAR   = 4'd6;
    localparam logic [3:0] CR_CACHE = 4'd7;
    localparam logic [3:0] CR_TLB   = 4'd8;

    localparam int MB_ICACHE_INV   = 0;
    localparam int MB_DCACHE_INV   = 1;
    localparam int MB_DCACHE_CLEAN = 2;
    localparam int MB_TLB_INV      = 3;

    localparam logic [31:0] CP15_ID = 32'h4107_B360;

    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_ABT = 5'b10111;
    localparam logic [4:0] M_UND = 5'b11011;
    localparam logic [4:0] M_SYS = 5'b11111;

    // Banked copies live above r15: FIQ r8-r14 at 16-22, then IRQ/SVC/ABT/UND r13-r14 pairs.
    function automatic logic [RW-1:0] translate(input logic [3:0] rd, input logic [4:0] mode);
        logic [RW-1:0] idx;
        logic          hi;
        idx = RW'(rd);
        hi  = (rd == 4'd13) || (rd == 4'd14);
        case (mode)
            M_FIQ: if (rd >= 4'd8 && rd <= 4'd14) idx = RW'(rd) + RW'(8);
            M_IRQ: if (hi) idx = RW'(rd) + RW'(10);
            M_SVC: if (hi) idx = RW'(rd) + RW'(12);
            M_ABT: if (hi) idx = RW'(rd) + RW'(14);
            M_UND: if (hi) idx = RW'(rd) + RW'(16);
            default: ;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/zap_cp15_sequencer_if.sv
// Predecode <-> CP15 sequencer link: dav/done handshake, core regfile port, maintenance.
interface zap_cp15_sequencer_if;
    import zap_cp15_sequencer_pkg::*;

    logic          i_cp_dav;
    logic [31:0]   i_cp_word;
    logic [4:0]    i_cpsr_ff_mode;
    logic          o_cp_done;
    logic [RW-1:0] o_reg_rd_index;
    logic [31:0]   i_reg_rd_data;
    logic          o_reg_wr_en;
    logic [RW-1:0] o_reg_wr_index;
    logic [31:0]   o_reg_wr_data;
    logic [3:0]    o_maint_req;
    logic          i_maint_ack;

    modport master (
        output i_cp_dav, i_cp_word, i_cpsr_ff_mode, i_reg_rd_data, i_maint_ack,
        input  o_cp_done, o_reg_rd_index, o_reg_wr_en, o_reg_wr_index,
        input  o_reg_wr_data, o_maint_req
    );

    modport slave (
        input  i_cp_dav, i_cp_word, i_cpsr_ff_mode, i_reg_rd_data, i_maint_ack,
        output o_cp_done, o_reg_rd_index, o_reg_wr_en, o_reg_wr_index,
        output o_reg_wr_data, o_maint_req
    );

endinterface

// File: rtl/zap_cp15_sequencer_regfile.sv
// CP15 register storage with MCR write port and MMU fault capture.
module zap_cp15_regfile
    import zap_cp15_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic        fault_wr,
    input  logic [31:0] fault_fsr,
    input  logic [31:0] fault_far,
    input  logic [3:0]  rd_sel,
    output logic [31:0] rd_data,
    output logic [31:0] ctrl,
    output logic [31:0] ttbr,
    output logic [31:0] dac,
    output logic [31:0] fsr,
    output logic [31:0] far
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
            ttbr <= '0;
            dac  <= '0;
            fsr  <= '0;
            far  <= '0;
        end else begin
            if (fault_wr) begin
                fsr <= fault_fsr;
                far <= fault_far;
            end
            // Later assignment wins: an MCR commit overrides a same-cycle fault.
            if (wr_en) begin
                case (wr_sel)
                    CR_CTRL: ctrl <= wr_data;
                    CR_TTBR: ttbr <= wr_data;
                    CR_DAC:  dac  <= wr_data;
                    CR_FSR:  fsr  <= wr_data;
                    CR_FAR:  far  <= wr_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            CR_ID:   rd_data = CP15_ID;
            CR_CTRL: rd_data = ctrl;
            CR_TTBR: rd_data = ttbr;
            CR_DAC:  rd_data = dac;
            CR_FSR:  rd_data = fsr;
            CR_FAR:  rd_data = far;
            default: rd_data = '0;
        endcase
    end

endmodule

// File: rtl/zap_cp15_sequencer.sv
// CP15 executor: decodes MCR/MRC, moves data to/from the core regfile,
// launches cache/TLB maintenance and completes via the dav/done handshake.
module zap_cp15_sequencer
    import zap_cp15_sequencer_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    zap_cp15_sequencer_if.slave  cp,
    input  logic                 i_fault_wr,
    input  logic [31:0]          i_fault_fsr,
    input  logic [31:0]          i_fault_far,
    output logic [31:0]          o_ctrl,
    output logic [31:0]          o_ttbr,
    output logic [31:0]          o_dac,
    output logic [31:0]          o_fsr,
    output logic [31:0]          o_far
);

    logic [2:0]  state;
    logic [3:0]  crn_q;
    logic [3:0]  rd_q;
    logic [4:0]  mode_q;

    logic [31:0] w;
    logic [3:0]  maint_bits;
    logic        acc;
    logic        is_mrc;
    logic        is_mnt;
    logic        is_mcr;
    logic [31:0] cp15_rd_data;
    logic        commit;

    assign w = cp.i_cp_word;

    always_comb begin
        maint_bits = '0;
        acc    = (w[27:24] == 4'b1110) && w[4] && (w[11:8] == 4'hF);
        if (acc && !w[20]) begin
            if (w[19:16] == CR_TLB) begin
                maint_bits[MB_TLB_INV] = 1'b1;
            end else if (w[19:16] == CR_CACHE) begin
                case (w[3:0])
                    4'd5:  maint_bits[MB_ICACHE_INV] = 1'b1;
                    4'd6:  maint_bits[MB_DCACHE_INV] = 1'b1;
                    4'd7:  maint_bits[1:0] = 2'b11;
                    4'd10: maint_bits[MB_DCACHE_CLEAN] = 1'b1;
                    default: ;
                endcase
            end
        end
        is_mrc = acc && w[20];
        is_mnt = acc && !w[20] && (|maint_bits);
        is_mcr = acc && !w[20] && (w[19:16] != CR_CACHE) && (w[19:16] != CR_TLB);
    end

    assign commit = (state == S_CAPT) && cp.i_cp_dav;

    assign cp.o_reg_rd_index = (state == S_RD) ? translate(rd_q, mode_q) : '0;

    zap_cp15_regfile u_regfile (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .wr_en     (commit),
        .wr_sel    (crn_q),
        .wr_data   (cp.i_reg_rd_data),
        .fault_wr  (i_fault_wr),
        .fault_fsr (i_fault_fsr),
        .fault_far (i_fault_far),
        .rd_sel    (w[19:16]),
        .rd_data   (cp15_rd_data),
        .ctrl      (o_ctrl),
        .ttbr      (o_ttbr),
        .dac       (o_dac),
        .fsr       (o_fsr),
        .far       (o_far)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state             <= S_IDLE;
            crn_q             <= '0;
            rd_q              <= '0;
            mode_q            <= '0;
            cp.o_cp_done      <= 1'b0;
            cp.o_reg_wr_en    <= 1'b0;
            cp.o_reg_wr_index <= '0;
            cp.o_reg_wr_data  <= '0;
            cp.o_maint_req    <= '0;
        end else begin
            cp.o_reg_wr_en <= 1'b0;
            case (state)
                S_IDLE: if (cp.i_cp_dav) begin
                    crn_q  <= w[19:16];
                    rd_q   <= w[15:12];
                    mode_q <= cp.i_cpsr_ff_mode;
                    unique case (1'b1)
                        is_mrc: begin
                            state             <= S_WRREG;
                            cp.o_reg_wr_en    <= (w[15:12] != 4'hF);
                            cp.o_reg_wr_index <= translate(w[15:12], cp.i_cpsr_ff_mode);
                            cp.o_reg_wr_data  <= cp15_rd_data;
                        end
                        is_mnt: begin
                            state          <= S_MAINT;
                            cp.o_maint_req <= maint_bits;
                        end
                        is_mcr: state <= S_RD;
                        default: begin
                            state        <= S_DONE;
                            cp.o_cp_done <= 1'b1;
                        end
                    endcase
                end
                S_RD: state <= cp.i_cp_dav ? S_CAPT : S_IDLE;
                S_CAPT, S_WRREG: begin
                    state        <= cp.i_cp_dav ? S_DONE : S_IDLE;
                    cp.o_cp_done <= cp.i_cp_dav;
                end
                // Maintenance cannot be cancelled; only the done is skipped.
                S_MAINT: if (cp.i_maint_ack) begin
                    cp.o_maint_req <= '0;
                    state          <= cp.i_cp_dav ? S_DONE : S_IDLE;
                    cp.o_cp_done   <= cp.i_cp_dav;
                end
                S_DONE: if (!cp.i_cp_dav) begin
                    state        <= S_IDLE;
                    cp.o_cp_done <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zap_cp15_sequencer.sv
// Directed bench for zap_cp15_sequencer with a one-cycle-latency core regfile model.
module tb_zap_cp15_sequencer;
    import zap_cp15_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fault_wr;
    logic [31:0] fault_fsr;
    logic [31:0] fault_far;
    logic [31:0] ctrl, ttbr, dac, fsr, far;
    logic [31:0] core [64];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    zap_cp15_sequencer_if cpif ();

    zap_cp15_sequencer dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .cp          (cpif),
        .i_fault_wr  (fault_wr),
        .i_fault_fsr (fault_fsr),
        .i_fault_far (fault_far),
        .o_ctrl      (ctrl),
        .o_ttbr      (ttbr),
        .o_dac       (dac),
        .o_fsr       (fsr),
        .o_far       (far)
    );

    always @(posedge clk) cpif.i_reg_rd_data <= core[cpif.o_reg_rd_index];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] word, input logic [4:0] mode);
        cpif.i_cp_word      = word;
        cpif.i_cpsr_ff_mode = mode;
        cpif.i_cp_dav       = 1'b1;
    endtask

    task automatic drop(input string tag);
        cpif.i_cp_dav = 1'b0;
        cyc();
        chk(tag, 32'(cpif.o_cp_done), 32'd0);
    endtask

    initial begin
        cpif.i_cp_dav = 1'b0;
        cpif.i_cp_word = '0;
        cpif.i_cpsr_ff_mode = M_USR;
        cpif.i_maint_ack = 1'b0;
        fault_wr = 1'b0;
        fault_fsr = '0;
        fault_far = '0;
        for (int i = 0; i < 64; i++) core[i] = '0;
        core[2] = 32'h0000_4000;
        core[4] = 32'h0000_0009;
        core[5] = 32'hABCD_0000;
        core[6] = 32'h0000_1005;

        #12;
        chk("rst_done", 32'(cpif.o_cp_done), 32'd0);
        chk("rst_maint", 32'(cpif.o_maint_req), 32'd0);
        chk("rst_wr_en", 32'(cpif.o_reg_wr_en), 32'd0);
        chk("rst_ctrl", ctrl, 32'd0);
        chk("rst_ttbr", ttbr, 32'd0);
        rst_n = 1'b1;
        cyc();

        // MCR p15, c2 from r2
        req(32'hEE02_2F10, M_USR);
        cyc();
        chk("mcr_rd_idx", 32'(cpif.o_reg_rd_index), 32'd2);
        chk("mcr_no_done_c1", 32'(cpif.o_cp_done), 32'd0);
        cyc();
        cyc();
        chk("mcr_ttbr", ttbr, 32'h0000_4000);
        chk("mcr_done_c3", 32'(cpif.o_cp_done), 32'd1);
        cyc();
        chk("mcr_done_hold", 32'(cpif.o_cp_done), 32'd1);
        drop("mcr_done_drop");

        // MRC p15, c0 into r3 (SVC)
        req(32'hEE10_3F10, M_SVC);
        cyc();
        chk("mrc_wr_en", 32'(cpif.o_reg_wr_en), 32'd1);
        chk("mrc_wr_idx", 32'(cpif.o_reg_wr_index), 32'd3);
        chk("mrc_wr_data", cpif.o_reg_wr_data, CP15_ID);
        cyc();
        chk("mrc_one_strobe", 32'(cpif.o_reg_wr_en), 32'd0);
        chk("mrc_done", 32'(cpif.o_cp_done), 32'd1);
        drop("mrc_done_drop");

        // MRC p15, c2 into banked r13_svc
        req(32'hEE12_DF10, M_SVC);
        cyc();
        chk("mrc_bank_idx", 32'(cpif.o_reg_wr_index), 32'd25);
        chk("mrc_ttbr_data", cpif.o_reg_wr_data, 32'h0000_4000);
        cyc();
        drop("mrc_bank_drop");

        // MRC into r15: no strobe
        req(32'hEE10_FF10, M_USR);
        cyc();
        chk("mrc_r15_no_wr", 32'(cpif.o_reg_wr_en), 32'd0);
        cyc();
        chk("mrc_r15_done", 32'(cpif.o_cp_done), 32'd1);
        drop("mrc_r15_drop");

        // c7 CRm=7: icache+dcache invalidate, ack after 5 cycles
        req(32'hEE07_0F17, M_USR);
        cyc();
        chk("maint_req", 32'(cpif.o_maint_req), 32'h3);
        repeat (4) cyc();
        chk("maint_held", 32'(cpif.o_maint_req), 32'h3);
        chk("maint_no_done", 32'(cpif.o_cp_done), 32'd0);
        cpif.i_maint_ack = 1'b1;
        cyc();
        cpif.i_maint_ack = 1'b0;
        chk("maint_cleared", 32'(cpif.o_maint_req), 32'h0);
        chk("maint_done", 32'(cpif.o_cp_done), 32'd1);
        drop("maint_drop");

        // c8 TLB invalidate with dav dropped during the wait
        req(32'hEE08_0F17, M_USR);
        cyc();
        chk("tlb_req", 32'(cpif.o_maint_req), 32'h8);
        cpif.i_cp_dav = 1'b0;
        cyc();
        chk("tlb_held", 32'(cpif.o_maint_req), 32'h8);
        cpif.i_maint_ack = 1'b1;
        cyc();
        cpif.i_maint_ack = 1'b0;
        chk("tlb_cleared", 32'(cpif.o_maint_req), 32'h0);
        chk("tlb_no_done", 32'(cpif.o_cp_done), 32'd0);
        cyc();
        chk("tlb_idle_no_done", 32'(cpif.o_cp_done), 32'd0);

        // c7 CRm=10: dcache clean
        req(32'hEE07_0F1A, M_USR);
        cyc();
        chk("clean_req", 32'(cpif.o_maint_req), 32'h4);
        cpif.i_maint_ack = 1'b1;
        cyc();
        cpif.i_maint_ack = 1'b0;
        chk("clean_done", 32'(cpif.o_cp_done), 32'd1);
        drop("clean_drop");

        // Fault capture alone
        fault_wr = 1'b1;
        fault_fsr = 32'h5;
        fault_far = 32'h0000_1234;
        cyc();
        fault_wr = 1'b0;
        chk("fault_fsr", fsr, 32'h5);
        chk("fault_far", far, 32'h0000_1234);

        // Fault colliding with MCR c5 commit
        req(32'hEE05_4F10, M_USR);
        cyc();
        cyc();
        fault_wr = 1'b1;
        fault_fsr = 32'h5;
        fault_far = 32'hDEAD_BEEF;
        cyc();
        fault_wr = 1'b0;
        chk("prio_fsr_mcr", fsr, 32'h9);
        chk("prio_far_fault", far, 32'hDEAD_BEEF);
        chk("prio_done", 32'(cpif.o_cp_done), 32'd1);
        drop("prio_drop");

        // cp#14 word: done at cycle 1, no side effects
        req(32'hEE02_2E10, M_USR);
        cyc();
        chk("cp14_done", 32'(cpif.o_cp_done), 32'd1);
        chk("cp14_no_wr", 32'(cpif.o_reg_wr_en), 32'd0);
        chk("cp14_no_maint", 32'(cpif.o_maint_req), 32'd0);
        drop("cp14_drop");

        // MCR c2 aborted in RD
        req(32'hEE02_5F10, M_USR);
        cyc();
        chk("abort_rd_idx", 32'(cpif.o_reg_rd_index), 32'd5);
        cpif.i_cp_dav = 1'b0;
        cyc();
        cyc();
        chk("abort_no_done", 32'(cpif.o_cp_done), 32'd0);
        chk("abort_ttbr", ttbr, 32'h0000_4000);

        // MCR c1 control
        req(32'hEE01_6F10, M_USR);
        repeat (3) cyc();
        chk("mcr_ctrl", ctrl, 32'h0000_1005);
        drop("ctrl_drop");

        // Asynchronous reset in the middle of maintenance
        req(32'hEE07_0F17, M_USR);
        cyc();
        cyc();
        chk("pre_rst_maint", 32'(cpif.o_maint_req), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("arst_maint", 32'(cpif.o_maint_req), 32'h0);
        chk("arst_done", 32'(cpif.o_cp_done), 32'd0);
        chk("arst_ctrl", ctrl, 32'd0);
        chk("arst_ttbr", ttbr, 32'd0);
        cpif.i_cp_dav = 1'b0;
        #5;
        rst_n = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
